// File: rtl/monitor_report_pkg.sv
// ---------------------------------------------------------------------------
// monitor_report_pkg
// Shared constants, the report-record layout and a width helper for the
// monitor report collector slice.
//
// Build option: define MONITOR_REPORT_TIMESTAMP_EN to prepend a free-running
// timestamp to every record. Left undefined, records carry only the
// report vector.
// ---------------------------------------------------------------------------
package monitor_report_pkg;

    // 9 LTL automata, each exposing 4 report outputs.
    localparam int N_REPORTS_C4          = 36;
    localparam int REPORTS_PER_AUTOMATON = 4;
    localparam int TS_W_C                = 16;

`ifdef MONITOR_REPORT_TIMESTAMP_EN
    localparam bit TIMESTAMP_EN = 1'b1;

    typedef struct packed {
        logic [TS_W_C-1:0]       timestamp;
        logic [N_REPORTS_C4-1:0] vector;
    } report_rec_t;
`else
    localparam bit TIMESTAMP_EN = 1'b0;

    typedef struct packed {
        logic [N_REPORTS_C4-1:0] vector;
    } report_rec_t;
`endif

    // Width of one buffered record for a given report/timestamp width.
    function automatic int rec_width(input int n_reports, input int ts_w);
        return TIMESTAMP_EN ? (n_reports + ts_w) : n_reports;
    endfunction

endpackage

// File: rtl/monitor_report_fifo.sv
// ---------------------------------------------------------------------------
// monitor_report_fifo
// Show-ahead FIFO: rd_data presents the oldest entry combinationally and
// reads as zero while empty.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   push, wr_data   - write request and data
//   pop             - remove the oldest entry (ignored while empty)
//   rd_data         - oldest entry, or 0 when empty
//   full, empty     - occupancy status
// ---------------------------------------------------------------------------
module monitor_report_fifo
    import monitor_report_pkg::*;
#(
    parameter int WIDTH = 52,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the
    // address bits coincide.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A full FIFO still accepts a write when the same edge frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update: reset wins over any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; no reset needed since empty masks stale contents.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/monitor_report_collector.sv
// ---------------------------------------------------------------------------
// monitor_report_collector
// Captures nonzero automata report vectors on run cycles into a record
// buffer, with overflow/drop accounting.
//
// Build option: MONITOR_REPORT_TIMESTAMP_EN adds a run-cycle timestamp
// counter and records become {timestamp, report_vec}.
//
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   run         - valid symbol cycle
//   report_vec  - automata reports, bit 4k+j = automaton k, report j
//   rep_valid   - a record is presented on rep_data
//   rep_ready   - reader accepts the presented record
//   rep_data    - oldest record, 0 when none
//   overflow    - sticky: at least one record was dropped
//   drop_cnt    - saturating count of dropped records
// ---------------------------------------------------------------------------
module monitor_report_collector
    import monitor_report_pkg::*;
#(
    parameter int N_REPORTS  = 36,
    parameter int FIFO_DEPTH = 16,
    parameter int TS_W       = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  run,
    input  logic [N_REPORTS-1:0]                  report_vec,
    output logic                                  rep_valid,
    input  logic                                  rep_ready,
    output logic [rec_width(N_REPORTS, TS_W)-1:0] rep_data,
    output logic                                  overflow,
    output logic [7:0]                            drop_cnt
);

    localparam int REC_W = rec_width(N_REPORTS, TS_W);

    logic             capture;
    logic             pop;
    logic             drop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [REC_W-1:0] record;

    assign capture   = run && (|report_vec);
    assign rep_valid = !fifo_empty;
    assign pop       = rep_valid && rep_ready;
    assign drop      = capture && fifo_full && !pop;

`ifdef MONITOR_REPORT_TIMESTAMP_EN
    logic [TS_W-1:0] timestamp;

    // Timestamp counts run cycles and wraps silently; a record captured in
    // a cycle carries the value held during that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            timestamp <= '0;
        end else if (run) begin
            timestamp <= timestamp + 1'b1;
        end
    end

    assign record = {timestamp, report_vec};
`else
    assign record = report_vec;
`endif

    monitor_report_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (capture),
        .wr_data (record),
        .pop     (pop),
        .rd_data (rep_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Drop accounting: sticky flag and saturating counter, cleared only by
    // reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_monitor_report_collector.sv
module tb_monitor_report_collector;

    localparam int N   = 36;
    localparam int D   = 16;
    localparam int TSW = 16;
`ifdef MONITOR_REPORT_TIMESTAMP_EN
    localparam int RW = N + TSW;
`else
    localparam int RW = N;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          run;
    logic [N-1:0]  report_vec;
    logic          rep_valid;
    logic          rep_ready;
    logic [RW-1:0] rep_data;
    logic          overflow;
    logic [7:0]    drop_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state: queue of records, run-cycle count, drop stats.
    logic [RW-1:0] mq[$];
    int            mts;
    bit            movf;
    int            mdrop;

    monitor_report_collector #(
        .N_REPORTS  (N),
        .FIFO_DEPTH (D),
        .TS_W       (TSW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .report_vec (report_vec),
        .rep_valid  (rep_valid),
        .rep_ready  (rep_ready),
        .rep_data   (rep_data),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Expected record for a timestamp and vector; the low RW bits drop the
    // timestamp field when records carry the vector only.
    function automatic logic [RW-1:0] make_rec(input int ts, input logic [N-1:0] v);
        logic [TSW-1:0]   t;
        logic [N+TSW-1:0] full_rec;
        t        = ts[TSW-1:0];
        full_rec = {t, v};
        return full_rec[RW-1:0];
    endfunction

    function automatic logic [N-1:0] rand_vec();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if (r[N-1:0] == '0) r[0] = 1'b1;
        return r[N-1:0];
    endfunction

    // Drive one cycle, advance the model by the same edge, sample 1ns later.
    task automatic applyStimulus(input logic r, input logic rn,
                                 input logic [N-1:0] v, input logic rdy);
        bit            do_pop;
        bit            do_push;
        logic [RW-1:0] rec;
        reset      = r;
        run        = rn;
        report_vec = v;
        rep_ready  = rdy;
        if (r) begin
            mq.delete();
            mts   = 0;
            movf  = 0;
            mdrop = 0;
        end else begin
            do_pop  = (mq.size() > 0) && rdy;
            do_push = rn && (v != '0);
            rec     = make_rec(mts, v);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                if (mq.size() < D) mq.push_back(rec);
                else begin
                    movf = 1;
                    if (mdrop < 255) mdrop++;
                end
            end
            if (rn) mts = (mts + 1) % (1 << TSW);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1, 1, rand_vec(), 1);
        total++; if (rep_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", rep_valid); end
        total++; if (rep_data !== '0) begin bad++; $display("[TB] FAIL reset_data: got %h expected 0", rep_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_drop: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_first_record();
        applyStimulus(1, 0, '0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, '0, 0);
        total++; if (rep_valid !== 1'b0) begin bad++; $display("[TB] FAIL zero_vec_no_push: got %b expected 0", rep_valid); end
        applyStimulus(0, 1, 36'h1, 0);
        total++; if (rep_valid !== 1'b1) begin bad++; $display("[TB] FAIL first_latency: got %b expected 1", rep_valid); end
        total++; if (rep_data !== make_rec(5, 36'h1)) begin bad++; $display("[TB] FAIL first_record: got %h expected %h", rep_data, make_rec(5, 36'h1)); end
        applyStimulus(0, 0, '0, 1);
        total++; if (rep_valid !== 1'b0) begin bad++; $display("[TB] FAIL first_pop: got %b expected 0", rep_valid); end
        applyStimulus(0, 0, '0, 1);
        total++; if (rep_valid !== 1'b0 || rep_data !== '0) begin bad++; $display("[TB] FAIL empty_ready: got %b/%h expected 0/0", rep_valid, rep_data); end
    endtask

    task automatic test_overflow_and_full_pushpop();
        logic [N-1:0] vecs [19];
        logic [N-1:0] nv;
        logic [RW-1:0] exp_rec;
        applyStimulus(1, 0, '0, 0);
        for (int i = 0; i < 19; i++) begin
            vecs[i] = rand_vec();
            applyStimulus(0, 1, vecs[i], 0);
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag: got %b expected 1", overflow); end
        total++; if (drop_cnt !== 8'd3) begin bad++; $display("[TB] FAIL ovf_drop: got %0d expected 3", drop_cnt); end
        total++; if (rep_data !== make_rec(0, vecs[0])) begin bad++; $display("[TB] FAIL ovf_oldest: got %h expected %h", rep_data, make_rec(0, vecs[0])); end
        nv = rand_vec();
        applyStimulus(0, 1, nv, 1);
        total++; if (drop_cnt !== 8'd3) begin bad++; $display("[TB] FAIL full_pushpop_drop: got %0d expected 3", drop_cnt); end
        total++; if (rep_data !== make_rec(1, vecs[1])) begin bad++; $display("[TB] FAIL full_pushpop_head: got %h expected %h", rep_data, make_rec(1, vecs[1])); end
        for (int k = 0; k < 16; k++) begin
            exp_rec = (k < 15) ? make_rec(k + 1, vecs[k + 1]) : make_rec(19, nv);
            total++; if (rep_valid !== 1'b1 || rep_data !== exp_rec) begin bad++; $display("[TB] FAIL drain_%0d: got %b/%h expected 1/%h", k, rep_valid, rep_data, exp_rec); end
            applyStimulus(0, 0, '0, 1);
        end
        total++; if (rep_valid !== 1'b0) begin bad++; $display("[TB] FAIL drain_empty: got %b expected 0", rep_valid); end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_run_toggle();
        applyStimulus(1, 0, '0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, '0, 0);
        applyStimulus(0, 1, 36'h8, 0);
        applyStimulus(0, 0, 36'h8, 0);
        applyStimulus(0, 0, 36'h8, 0);
        applyStimulus(0, 1, 36'h8, 0);
        total++; if (rep_data !== make_rec(3, 36'h8)) begin bad++; $display("[TB] FAIL toggle_rec0: got %h expected %h", rep_data, make_rec(3, 36'h8)); end
        applyStimulus(0, 0, '0, 1);
        total++; if (rep_valid !== 1'b1 || rep_data !== make_rec(4, 36'h8)) begin bad++; $display("[TB] FAIL toggle_rec1: got %b/%h expected 1/%h", rep_valid, rep_data, make_rec(4, 36'h8)); end
        applyStimulus(0, 0, '0, 1);
        total++; if (rep_valid !== 1'b0) begin bad++; $display("[TB] FAIL toggle_count: got %b expected 0", rep_valid); end
    endtask

    task automatic test_ts_wrap();
        applyStimulus(1, 0, '0, 0);
        for (int i = 0; i < 65535; i++) applyStimulus(0, 1, '0, 0);
        applyStimulus(0, 1, 36'h2, 0);
        applyStimulus(0, 1, 36'h4, 0);
        total++; if (rep_data !== make_rec(65535, 36'h2)) begin bad++; $display("[TB] FAIL wrap_last: got %h expected %h", rep_data, make_rec(65535, 36'h2)); end
        applyStimulus(0, 0, '0, 1);
        total++; if (rep_data !== make_rec(0, 36'h4)) begin bad++; $display("[TB] FAIL wrap_zero: got %h expected %h", rep_data, make_rec(0, 36'h4)); end
        applyStimulus(0, 0, '0, 1);
    endtask

    task automatic test_reset_mid_transfer();
        logic [N-1:0] v;
        applyStimulus(1, 0, '0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, rand_vec(), 0);
        for (int i = 0; i < 24; i++) applyStimulus(0, 0, '0, logic'(i % 2 == 0));
        total++; if (mq.size() != 4 || rep_valid !== 1'b1) begin bad++; $display("[TB] FAIL mid_setup: got valid=%b model=%0d expected 1/4", rep_valid, mq.size()); end
        applyStimulus(1, 1, rand_vec(), 1);
        total++; if (rep_valid !== 1'b0 || rep_data !== '0) begin bad++; $display("[TB] FAIL mid_reset_fifo: got %b/%h expected 0/0", rep_valid, rep_data); end
        total++; if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin bad++; $display("[TB] FAIL mid_reset_stats: got %b/%0d expected 0/0", overflow, drop_cnt); end
        v = rand_vec();
        applyStimulus(0, 1, v, 0);
        total++; if (rep_data !== make_rec(0, v)) begin bad++; $display("[TB] FAIL post_reset_ts0: got %h expected %h", rep_data, make_rec(0, v)); end
    endtask

    task automatic test_random();
        logic [N-1:0]  v;
        logic [RW-1:0] exp_data;
        applyStimulus(1, 0, '0, 0);
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(2) == 0) ? '0 : rand_vec();
            applyStimulus(0, logic'($urandom_range(3) != 0), v, logic'($urandom_range(2) == 0));
            exp_data = (mq.size() > 0) ? mq[0] : '0;
            total++; if (rep_valid !== (mq.size() > 0) || rep_data !== exp_data) begin bad++; $display("[TB] FAIL rand_rec_%0d: got %b/%h expected %b/%h", i, rep_valid, rep_data, (mq.size() > 0), exp_data); end
            total++; if (overflow !== movf || drop_cnt !== 8'(mdrop)) begin bad++; $display("[TB] FAIL rand_stats_%0d: got %b/%0d expected %b/%0d", i, overflow, drop_cnt, movf, mdrop); end
        end
    endtask

    initial begin
        reset      = 1'b1;
        run        = 1'b0;
        report_vec = '0;
        rep_ready  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_first_record();
        test_overflow_and_full_pushpop();
        test_run_toggle();
        test_ts_wrap();
        test_reset_mid_transfer();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/monitor_report_collector.md
MONITOR_REPORT_COLLECTOR -- requirements
Module: monitor_report_collector

Interface
REQ-001 Parameter N_REPORTS, default 36, shall set the report-vector width (9 LTL automata x 4 reports per stage).
REQ-002 Parameter FIFO_DEPTH, default 16, shall set the record-buffer depth and shall be a power of two, >= 2.
REQ-003 Parameter TS_W, default 16, shall set the timestamp width.
REQ-004 clk  input  1  shall be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  shall be the synchronous, active-high reset.
REQ-006 run  input  1  shall qualify a valid symbol cycle, the same run that drives the automata stage.
REQ-007 report_vec  input  N_REPORTS  shall carry the automata report outputs: bit 4k+j = automaton k, report j (j = 0..3 maps to w_out_4/6/9/11).
REQ-008 rep_valid  output  1  shall indicate that a record is presented.
REQ-009 rep_ready  input  1  shall indicate that the reader accepts the presented record.
REQ-010 rep_data  output  TS_W+N_REPORTS (N_REPORTS without timestamps)  shall be the record: {timestamp, vector}.
REQ-011 overflow  output  1  shall be a sticky flag set when any record is dropped.
REQ-012 drop_cnt  output  8  shall count dropped records.

Function
REQ-013 Timestamp counter: +1 per clk with run=1; holds when run=0; wraps modulo 2^TS_W with no flag.
REQ-014 Capture: cycle N with run=1 and report_vec != 0 -> push {timestamp value during cycle N, report_vec}.
  - report_vec = 0, or run = 0 -> no push.
REQ-015 Latency: a record pushed into an empty buffer at cycle N shall give rep_valid=1 at cycle N+1.
REQ-016 Buffer: show-ahead FIFO; rep_data = oldest record whenever rep_valid=1; rep_data = 0 when empty.
REQ-017 Pop: occurs when rep_valid & rep_ready at a rising edge; rep_ready with rep_valid=0 shall have no effect.
REQ-018 Handshake stability: while rep_valid=1 and rep_ready=0, rep_data shall hold stable.
REQ-019 Full FIFO + push without pop in the same cycle:
  - record is dropped
  - overflow <= 1
  - drop_cnt +1, saturating at 255
REQ-020 Full FIFO + simultaneous push and pop: both complete; occupancy unchanged; no drop.
REQ-021 Empty FIFO + simultaneous push and pop request: no pop (rep_valid=0); push completes.
REQ-022 Read/write pointers: log2(FIFO_DEPTH)+1 bits, wrap-around; full/empty derived from pointer MSB comparison.
REQ-023 overflow and drop_cnt shall clear only on reset.

Reset
REQ-024 On reset=1 at a rising edge, the following shall be cleared; reset overrides run, pushes and pops in that cycle:
  - timestamp = 0
  - FIFO pointers = 0
  - rep_valid = 0
  - rep_data = 0
  - overflow = 0
  - drop_cnt = 0
REQ-025 Reset mid-transfer shall discard all buffered records; the first post-reset record shall carry timestamp 0 if captured on the first run cycle.

Configuration
REQ-026 Macro MONITOR_REPORT_TIMESTAMP_EN defined: counter present; rep_data = {timestamp[TS_W-1:0], report_vec}.
REQ-027 Macro undefined: no counter logic; rep_data = report_vec only (N_REPORTS bits); all other behaviour identical.

Structure
REQ-028 Package monitor_report_pkg shall hold:
  - N_REPORTS_C4 = 36
  - REPORTS_PER_AUTOMATON = 4
  - the report-record typedef (timestamp and vector fields, layout conditional on the macro)
REQ-029 Sub-module monitor_report_fifo (parameterized width/depth, show-ahead, full/empty outputs) shall implement the buffer; monitor_report_collector shall hold the counter, capture qualification and drop accounting.

Verification
REQ-030 Reset, then run=1 for 5 cycles with report_vec=0, then report_vec=36'h1 at cycle 5 -> one record {ts=5, 36'h1}; rep_valid at cycle 6.
REQ-031 rep_ready=0; 16 consecutive nonzero vectors, then 3 more -> FIFO holds the first 16 in order; overflow=1; drop_cnt=3.
REQ-032 FIFO full, rep_ready=1 and a new push in the same cycle -> no drop; occupancy stays 16; oldest record popped.
REQ-033 run toggling 1,0,0,1 with report_vec=36'h8 each cycle -> 2 records, timestamps t and t+1.
REQ-034 Counter preset near 2^16-1 via 65535 run cycles; report at ts 65535 and at the next run cycle -> timestamps 65535 then 0.
REQ-035 Reset asserted with 4 records buffered and rep_ready toggling -> next cycle: rep_valid=0, overflow=0, drop_cnt=0.
